// File: rtl/cdc_rx_bridge.sv
// USB CDC OUT byte FIFO with CPU DATA/STATUS registers and CR line tracking.
// Define CDC_RX_LF_DROP_EN to accept LF (0x0A) bytes without storing them.
module cdc_rx_bridge #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        cpu_rd,
  input  logic        cpu_addr,
  output logic [15:0] cpu_rdata,
  output logic        line_avail
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam ptr_t PTR_ONE  = ptr_t'(1);

  logic [7:0]  mem_q [DEPTH];
  ptr_t        wr_q, wr_d;
  ptr_t        rd_q, rd_d;
  cnt_t        cnt_q, cnt_d;
  cnt_t        cr_q, cr_d;
  logic [15:0] rdata_q, rdata_d;

  logic        full, empty;
  logic        push, store, pop;
  logic        cr_in, cr_out;
  logic [7:0]  head;
  logic [7:0]  cnt8;
  logic [15:0] status;

  assign full     = (cnt_q == CNT_FULL);
  assign empty    = (cnt_q == '0);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;

`ifdef CDC_RX_LF_DROP_EN
  assign store = push && (in_data != 8'h0A);
`else
  assign store = push;
`endif

  assign pop    = cpu_rd && !cpu_addr && !empty && !rst;
  assign head   = mem_q[rd_q];
  assign cr_in  = store && (in_data == 8'h0D);
  assign cr_out = pop && (head == 8'h0D);

  assign line_avail = (cr_q != '0) && !rst;
  assign cnt8       = 8'(cnt_q);
  // Status reflects pre-update state of the read cycle
  assign status = {cnt8, 5'b0, line_avail, full, !empty};

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    cr_d    = cr_q;
    rdata_d = rdata_q;
    if (store) wr_d = wr_q + PTR_ONE;
    if (pop)   rd_d = rd_q + PTR_ONE;
    unique case ({store, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    unique case ({cr_in, cr_out})
      2'b10:   cr_d = cr_q + CNT_ONE;
      2'b01:   cr_d = cr_q - CNT_ONE;
      default: cr_d = cr_q;
    endcase
    if (cpu_rd) begin
      if (cpu_addr)   rdata_d = status;
      else if (empty) rdata_d = 16'h0000;
      else            rdata_d = {8'h00, head};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      cr_q    <= '0;
      rdata_q <= 16'h0000;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      cr_q    <= cr_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem_q[wr_q] <= in_data;
  end

  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_cdc_rx_bridge.sv
// Scoreboard bench for cdc_rx_bridge: reads queue expected data,
// a negedge monitor pops and compares each registered response.
module tb_cdc_rx_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        cpu_rd = 1'b0;
  logic        cpu_addr = 1'b0;
  logic [15:0] cpu_rdata;
  logic        line_avail;

  int checks = 0;
  int failures = 0;
  logic [15:0] exq[$];
  logic rd_pend = 1'b0;

  cdc_rx_bridge #(.DEPTH_LOG2(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .cpu_rd(cpu_rd),
    .cpu_addr(cpu_addr),
    .cpu_rdata(cpu_rdata),
    .line_avail(line_avail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_pend <= cpu_rd && !rst;

  always @(negedge clk) begin
    if (rd_pend) begin
      checks++;
      if (exq.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected got=%h", cpu_rdata);
      end else begin
        logic [15:0] e;
        e = exq.pop_front();
        if (cpu_rdata !== e) begin
          failures++;
          $display("FAIL rdata got=%h exp=%h", cpu_rdata, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cpu_rd = 1'b0;
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic push(input logic [7:0] b);
    bit done = 0;
    in_valid = 1'b1;
    in_data = b;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) done = 1;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL push_timeout got=0 exp=1 byte=%h", b);
    end
  endtask

  task automatic rd(input logic addr, input logic [15:0] exp);
    cpu_rd = 1'b1;
    cpu_addr = addr;
    exq.push_back(exp);
    step();
    cpu_rd = 1'b0;
  endtask

  logic [7:0] msg [7];
  int acc;

  initial begin
    msg[0] = 8'h31; msg[1] = 8'h20; msg[2] = 8'h32; msg[3] = 8'h20;
    msg[4] = 8'h2B; msg[5] = 8'h20; msg[6] = 8'h2E;

    // power-on reset
    #1;
    check("rst_in_ready", 16'(in_ready), 16'h0);
    check("rst_line", 16'(line_avail), 16'h0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("rdata_reset", cpu_rdata, 16'h0000);
    check("ready_after_rst", 16'(in_ready), 16'h1);
    rd(1'b1, 16'h0000);

    // ordering
    foreach (msg[i]) push(msg[i]);
    rd(1'b1, 16'h0701);
    foreach (msg[i]) rd(1'b0, {8'h00, msg[i]});
    rd(1'b0, 16'h0000);
    rd(1'b1, 16'h0000);
    idle(1);
    check("hold_rdata", cpu_rdata, 16'h0000);

    // full / backpressure
    acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_data = 8'h40 + 8'(acc);
      if (in_ready) acc++;
      step();
    end
    check("accepted", 16'(acc), 16'd16);
    check("full_ready", 16'(in_ready), 16'h0);
    in_data = 8'h50;
    rd(1'b1, 16'h1003);
    rd(1'b0, 16'h0040);
    check("ready_after_pop", 16'(in_ready), 16'h1);
    step();
    in_valid = 1'b0;
    rd(1'b1, 16'h1003);
    for (int k = 1; k <= 16; k++) rd(1'b0, {8'h00, 8'h40 + 8'(k)});
    rd(1'b1, 16'h0000);

    // simultaneous push and pop at count 5
    for (int k = 0; k < 5; k++) push(8'h61 + 8'(k));
    in_valid = 1'b1;
    in_data = 8'h66;
    rd(1'b0, 16'h0061);
    in_valid = 1'b0;
    rd(1'b1, 16'h0501);
    for (int k = 0; k < 5; k++) rd(1'b0, {8'h00, 8'h62 + 8'(k)});

    // line tracking
    push(8'h41);
    push(8'h42);
    check("line_before_cr", 16'(line_avail), 16'h0);
    push(8'h0D);
    check("line_set", 16'(line_avail), 16'h1);
    rd(1'b1, 16'h0305);
    rd(1'b0, 16'h0041);
    rd(1'b0, 16'h0042);
    check("line_held", 16'(line_avail), 16'h1);
    rd(1'b0, 16'h000D);
    check("line_clear", 16'(line_avail), 16'h0);

    // LF handling
    push(8'h0D);
    push(8'h0A);
`ifdef CDC_RX_LF_DROP_EN
    rd(1'b1, 16'h0105);
    rd(1'b0, 16'h000D);
    rd(1'b0, 16'h0000);
`else
    rd(1'b1, 16'h0205);
    rd(1'b0, 16'h000D);
    rd(1'b0, 16'h000A);
`endif

    // reset mid-transfer
    push(8'h71);
    push(8'h0D);
    push(8'h72);
    in_valid = 1'b1;
    in_data = 8'h73;
    rst = 1'b1;
    #1;
    check("midrst_ready0", 16'(in_ready), 16'h0);
    check("midrst_line0", 16'(line_avail), 16'h0);
    step();
    check("midrst_ready1", 16'(in_ready), 16'h0);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_line", 16'(line_avail), 16'h0);
    check("post_rst_rdata", cpu_rdata, 16'h0000);
    rd(1'b1, 16'h0000);
    push(8'h5A);
    rd(1'b0, 16'h005A);
    rd(1'b0, 16'h0000);

    idle(3);
    check("scoreboard_empty", 16'(exq.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
